fpga_rst_seq: RTL and testbench



---
 rtl/fpga_rst_seq_if.sv | 35 +++
 rtl/fpga_rst_seq.sv | 159 +++++++++++++++
 tb/tb_fpga_rst_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_rst_seq_if.sv
// Reset-sequencer subsystem bundle: per-stage ready inputs and the
// sequencer's per-stage resets plus completion/fault status.
//   rdy_i       : per-stage ready from the subsystems
//   rst_o       : per-stage active-high reset to the subsystems
//   done_o      : every stage released and ready
//   err_o       : sticky stage-timeout flag
//   err_stage_o : index of the stage that timed out
// master = sequencer side, slave = subsystem / observer side.
interface fpga_rst_seq_if #(
  parameter int unsigned NUM_STAGES = 3
) ();

  logic [NUM_STAGES-1:0] rdy_i;
  logic [NUM_STAGES-1:0] rst_o;
  logic                  done_o;
  logic                  err_o;
  logic [3:0]            err_stage_o;

  modport master (
    input  rdy_i,
    output rst_o,
    output done_o,
    output err_o,
    output err_stage_o
  );

  modport slave (
    output rdy_i,
    input  rst_o,
    input  done_o,
    input  err_o,
    input  err_stage_o
  );

endinterface

// File: rtl/fpga_rst_seq.sv
// Staged reset sequencer: after srst_in/areset release, deasserts one
// subsystem reset at a time, DLY_CYCLES after the previous stage reported
// ready, and re-holds everything with a sticky error if a stage times out.
//   clk     : PLL output clock (sole clock)
//   areset  : asynchronous active-high reset
//   srst_in : synchronous active-high reset, already in the clk domain
//   bus     : master side of fpga_rst_seq_if (rdy_i in; rst_o/done_o/
//             err_o/err_stage_o out, all registered)
module fpga_rst_seq #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned DLY_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           srst_in,
  fpga_rst_seq_if.master bus
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_DELAY = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      tcnt_q, tcnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [3:0]            err_stage_q, err_stage_d;

  // One-hot select of the current stage; avoids a variable bit-select that
  // would be zero-width when NUM_STAGES is 1.
  logic [NUM_STAGES-1:0] sel_c;
  logic                  rdy_sel_c;

  assign sel_c     = NUM_STAGES'(1) << idx_q;
  assign rdy_sel_c = |(bus.rdy_i & sel_c);

  // State and output registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      rst_q       <= '1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      rst_q       <= rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  // Next-state and counter logic; srst_in overrides every state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    if (srst_in) begin
      state_d = S_HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          state_d = S_DELAY;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            state_d = S_WAIT;
            tcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // Ready wins over a timeout landing on the same edge
          if (rdy_sel_c) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DELAY;
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
            end
          end else if (TMO_EN) begin
            if (tcnt_q == TMO_LAST) begin
              state_d = S_FAULT;
            end else begin
              tcnt_d = tcnt_q + CNT_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_HOLD;
      endcase
    end
  end

  // Next registered outputs, derived from the state being entered
  always_comb begin
    rst_d       = rst_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_stage_d = '0;
    case (state_d)
      S_HOLD:  rst_d = '1;
      S_DONE: begin
        rst_d  = '0;
        done_d = 1'b1;
      end
      S_FAULT: begin
        rst_d       = '1;
        err_d       = 1'b1;
        err_stage_d = 4'(idx_d);
      end
      S_DELAY, S_WAIT: begin
        // Released bits only ever clear here; they never re-assert singly
        if (state_q == S_DELAY && state_d == S_WAIT) begin
          rst_d = rst_q & ~sel_c;
        end
      end
      default: rst_d = '1;
    endcase
  end

  assign bus.rst_o       = rst_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.err_stage_o = err_stage_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq: two instances (timeout 8 and timeout disabled),
// randomized ready latencies and noise on non-awaited ready bits, checked by
// a queue scoreboard fed from an event-timeline reference model.
module tb_fpga_rst_seq;

  localparam int unsigned NS  = 3;
  localparam int unsigned DLY = 4;

  typedef struct packed {
    logic [2:0] rst;
    logic       done;
    logic       err;
    logic [3:0] stage;
  } exp_t;

  logic       clk    = 1'b0;
  logic       ares_a = 1'b1;
  logic       ares_b = 1'b1;
  logic       srst_a = 1'b1;
  logic       srst_b = 1'b1;
  logic [2:0] rdy_a  = 3'b000;
  logic [2:0] rdy_b  = 3'b000;

  always #5 clk = ~clk;

  fpga_rst_seq_if #(.NUM_STAGES(NS)) bus_a ();
  fpga_rst_seq_if #(.NUM_STAGES(NS)) bus_b ();

  assign bus_a.rdy_i = rdy_a;
  assign bus_b.rdy_i = rdy_b;

  fpga_rst_seq #(
    .NUM_STAGES(NS), .DLY_CYCLES(DLY), .TIMEOUT_CYCLES(8), .CNT_W(16)
  ) dut_a (
    .clk(clk), .areset(ares_a), .srst_in(srst_a), .bus(bus_a)
  );

  fpga_rst_seq #(
    .NUM_STAGES(NS), .DLY_CYCLES(DLY), .TIMEOUT_CYCLES(0), .CNT_W(16)
  ) dut_b (
    .clk(clk), .areset(ares_b), .srst_in(srst_b), .bus(bus_b)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Event timeline per lane: edge numbers of each release, acceptance,
  // fault and completion, derived from the sequence start edge.
  int tmo     [2] = '{8, 0};
  int start   [2] = '{-1, -1};
  int lat     [2][3];
  int rel     [2][3];
  int acc     [2][3];
  int reach   [2];
  int fault_e [2];
  int fault_k [2];
  int done_e  [2];

  exp_t q0[$];
  exp_t q1[$];

  task automatic cmp(string name, int lane, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s lane%0d edge %0d: got %0d expected %0d",
               name, lane, edge_n, act, expv);
    end
  endtask

  function automatic void build(int l);
    int t;
    t = start[l] + int'(DLY);
    fault_e[l] = -1;
    fault_k[l] = 0;
    done_e[l]  = -1;
    reach[l]   = 0;
    for (int k = 0; k < 3; k++) begin
      rel[l][k] = t;
      reach[l]  = k + 1;
      if (tmo[l] != 0 && lat[l][k] > tmo[l]) begin
        fault_e[l] = t + tmo[l];
        fault_k[l] = k;
        break;
      end
      acc[l][k] = t + lat[l][k];
      if (k == 2) done_e[l] = acc[l][k];
      else        t = acc[l][k] + int'(DLY);
    end
  endfunction

  function automatic exp_t model(int l, int e);
    exp_t x;
    x.rst   = 3'b111;
    x.done  = 1'b0;
    x.err   = 1'b0;
    x.stage = 4'd0;
    if (start[l] < 0) return x;
    if (fault_e[l] >= 0 && e >= fault_e[l]) begin
      x.err   = 1'b1;
      x.stage = 4'(fault_k[l]);
      return x;
    end
    if (done_e[l] >= 0 && e >= done_e[l]) begin
      x.rst  = 3'b000;
      x.done = 1'b1;
      return x;
    end
    for (int k = 0; k < reach[l]; k++)
      if (e >= rel[l][k]) x.rst[k] = 1'b0;
    return x;
  endfunction

  // Awaited bit low until its scheduled edge, high on it; all else random
  function automatic logic [2:0] gen_rdy(int l, int e);
    logic [2:0] r;
    r = 3'($urandom);
    if (start[l] >= 0) begin
      for (int k = 0; k < reach[l]; k++) begin
        if (e > rel[l][k] && e < rel[l][k] + lat[l][k]) r[k] = 1'b0;
        else if (e == rel[l][k] + lat[l][k])            r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // Drive inputs for upcoming edge e and queue the outputs expected after it
  task automatic drive(int l, int e, bit s);
    exp_t       x;
    logic [2:0] r;
    if (s) start[l] = -1;
    else if (start[l] < 0) begin
      start[l] = e;
      build(l);
    end
    x = model(l, e);
    r = gen_rdy(l, e);
    if (l == 0) begin
      srst_a = s;
      rdy_a  = r;
      q0.push_back(x);
    end else begin
      srst_b = s;
      rdy_b  = r;
      q1.push_back(x);
    end
  endtask

  task automatic run_seq(int l, int l0, int l1, int l2, int extra,
                         bit abort, bit ares_done);
    int e;
    int end_e;
    bit first;
    first = 1'b1;
    end_e = 0;
    lat[l][0] = l0;
    lat[l][1] = l1;
    lat[l][2] = l2;
    forever begin
      @(negedge clk);
      e = edge_n + 1;
      if (first) begin
        drive(l, e, 1'b0);
        first = 1'b0;
        end_e = ((fault_e[l] >= 0) ? fault_e[l] : done_e[l]) + extra;
      end else if (abort && e == acc[l][1] + 2) begin
        drive(l, e, 1'b1);
        break;
      end else if (e > end_e) begin
        if (ares_done) begin
          ares_a = 1'b1;
          #1;
          cmp("async_rst_o", l, int'(bus_a.rst_o), 7);
          cmp("async_done_o", l, int'(bus_a.done_o), 0);
          cmp("async_err_o", l, int'(bus_a.err_o), 0);
          drive(l, e, 1'b1);
          @(negedge clk);
          ares_a = 1'b0;
          drive(l, edge_n + 1, 1'b1);
        end else begin
          drive(l, e, 1'b1);
        end
        break;
      end else begin
        drive(l, e, 1'b0);
      end
    end
  endtask

  // Scoreboard monitors: one expectation per edge, checked just after it
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      cmp("rst_o", 0, int'(bus_a.rst_o), int'(x.rst));
      cmp("done_o", 0, int'(bus_a.done_o), int'(x.done));
      cmp("err_o", 0, int'(bus_a.err_o), int'(x.err));
      cmp("err_stage_o", 0, int'(bus_a.err_stage_o), int'(x.stage));
    end
  end

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q1.size() > 0) begin
      x = q1.pop_front();
      cmp("rst_o", 1, int'(bus_b.rst_o), int'(x.rst));
      cmp("done_o", 1, int'(bus_b.done_o), int'(x.done));
      cmp("err_o", 1, int'(bus_b.err_o), int'(x.err));
      cmp("err_stage_o", 1, int'(bus_b.err_stage_o), int'(x.stage));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lane A (timeout 8): power-up reset, then srst_in still held
    repeat (3) begin
      @(negedge clk);
      drive(0, edge_n + 1, 1'b1);
    end
    @(negedge clk);
    ares_a = 1'b0;
    drive(0, edge_n + 1, 1'b1);
    @(negedge clk);
    drive(0, edge_n + 1, 1'b1);

    run_seq(0, 2, 2, 1, 3, 1'b0, 1'b0);    // nominal staged release
    run_seq(0, 8, 1, 3, 2, 1'b0, 1'b0);    // ready on the last timeout edge
    run_seq(0, 1, 9, 1, 110, 1'b0, 1'b0);  // stage 1 times out, fault persists
    run_seq(0, 3, 2, 2, 0, 1'b1, 1'b0);    // srst_in during stage-2 delay
    run_seq(0, 3, 2, 2, 2, 1'b0, 1'b0);    // restart with identical timing
    repeat (10) begin
      run_seq(0, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)),
              int'($urandom_range(1, 10)), int'($urandom_range(1, 5)),
              1'b0, 1'b0);
    end
    run_seq(0, 2, 3, 2, 3, 1'b0, 1'b1);    // areset pulse while in DONE

    // Lane B (timeout disabled)
    @(negedge clk);
    ares_b = 1'b0;
    drive(1, edge_n + 1, 1'b1);
    @(negedge clk);
    drive(1, edge_n + 1, 1'b1);
    run_seq(1, 5000, 2, 3, 3, 1'b0, 1'b0);
    repeat (4) begin
      run_seq(1, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
              int'($urandom_range(1, 40)), int'($urandom_range(1, 5)),
              1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    cmp("queue_drain", 2, q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
